// File: rtl/cpu_debug_ctrl.sv
// Host-side debug sequencer for cpu_4bit: imem load, core reset, single-step, run and halt.
// Define CPU_DEBUG_BREAKPOINT_EN to add a PC breakpoint (bp_en_i/bp_addr_i) checked in RUN.
module cpu_debug_ctrl #(
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned INSTR_W    = 8,
    parameter int unsigned RST_CYCLES = 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [1:0]         cmd_op_i,
    input  logic [ADDR_W-1:0]  cmd_addr_i,
    input  logic [INSTR_W-1:0] cmd_data_i,
    input  logic [3:0]         cmd_count_i,
    input  logic               halt_req_i,
`ifdef CPU_DEBUG_BREAKPOINT_EN
    input  logic               bp_en_i,
    input  logic [ADDR_W-1:0]  bp_addr_i,
`endif
    input  logic [ADDR_W-1:0]  pc_i,
    output logic               imem_we_o,
    output logic [ADDR_W-1:0]  imem_waddr_o,
    output logic [INSTR_W-1:0] imem_wdata_o,
    output logic               cpu_en_o,
    output logic               cpu_rst_o,
    output logic               done_o,
    output logic               err_o,
    output logic [1:0]         stop_cause_o
);

    typedef enum logic [2:0] {StHalted, StWrite, StReset, StStep, StRun} state_e;

    localparam logic [1:0] OpWrite   = 2'b00;
    localparam logic [1:0] OpReset   = 2'b01;
    localparam logic [1:0] OpStep    = 2'b10;
    localparam logic [1:0] OpRun     = 2'b11;
    localparam logic [1:0] CauseDone = 2'd0;
    localparam logic [1:0] CauseHalt = 2'd1;
    localparam logic [1:0] CauseBp   = 2'd2;

    state_e               state_q, state_d;
    logic                 released_q, released_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [ADDR_W-1:0]    waddr_q, waddr_d;
    logic [INSTR_W-1:0]   wdata_q, wdata_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [1:0]           cause_q, cause_d;
    logic                 bp_hit;
    logic                 run_start;

`ifdef CPU_DEBUG_BREAKPOINT_EN
    // Skip the compare on the first RUN cycle so a run can resume from the breakpoint PC.
    logic first_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            first_q <= 1'b0;
        end else begin
            first_q <= run_start;
        end
    end

    assign bp_hit = bp_en_i && (pc_i == bp_addr_i) && !first_q;
`else
    logic unused_pc;
    logic unused_run_start;
    assign unused_pc        = ^pc_i;
    assign unused_run_start = run_start;
    assign bp_hit           = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        released_d = released_q;
        cnt_d      = cnt_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        cause_d    = CauseDone;
        run_start  = 1'b0;
        cpu_en_o   = 1'b0;
        imem_we_o  = 1'b0;

        unique case (state_q)
            StHalted: begin
                if (cmd_valid_i) begin
                    unique case (cmd_op_i)
                        OpWrite: begin
                            if (released_q) begin
                                err_d = 1'b1;
                            end else begin
                                state_d = StWrite;
                                waddr_d = cmd_addr_i;
                                wdata_d = cmd_data_i;
                            end
                        end
                        OpReset: begin
                            state_d = StReset;
                            cnt_d   = 4'(RST_CYCLES);
                        end
                        OpStep: begin
                            if (!released_q) begin
                                err_d = 1'b1;
                            end else if (cmd_count_i == 4'd0) begin
                                done_d = 1'b1;
                            end else begin
                                state_d = StStep;
                                cnt_d   = cmd_count_i;
                            end
                        end
                        default: begin
                            if (!released_q) begin
                                err_d = 1'b1;
                            end else begin
                                state_d   = StRun;
                                run_start = 1'b1;
                            end
                        end
                    endcase
                end
            end
            StWrite: begin
                imem_we_o = 1'b1;
                state_d   = StHalted;
                done_d    = 1'b1;
            end
            StReset: begin
                cpu_en_o = 1'b1;
                if (cnt_q <= 4'd1) begin
                    state_d    = StHalted;
                    released_d = 1'b1;
                    done_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StStep: begin
                if (halt_req_i) begin
                    state_d = StHalted;
                    done_d  = 1'b1;
                    cause_d = CauseHalt;
                end else begin
                    cpu_en_o = 1'b1;
                    if (cnt_q == 4'd1) begin
                        state_d = StHalted;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            StRun: begin
                // halt_req takes priority over a coincident breakpoint.
                if (halt_req_i) begin
                    state_d = StHalted;
                    done_d  = 1'b1;
                    cause_d = CauseHalt;
                end else if (bp_hit) begin
                    state_d = StHalted;
                    done_d  = 1'b1;
                    cause_d = CauseBp;
                end else begin
                    cpu_en_o = 1'b1;
                end
            end
            default: state_d = StHalted;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StHalted;
            released_q <= 1'b0;
            cnt_q      <= 4'd0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cause_q    <= CauseDone;
        end else begin
            state_q    <= state_d;
            released_q <= released_d;
            cnt_q      <= cnt_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cause_q    <= cause_d;
        end
    end

    assign cmd_ready_o  = (state_q == StHalted);
    assign cpu_rst_o    = !released_q || (state_q == StReset);
    assign imem_waddr_o = waddr_q;
    assign imem_wdata_o = wdata_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign stop_cause_o = cause_q;

endmodule

// File: tb/tb_cpu_debug_ctrl.sv
// Directed self-checking bench for cpu_debug_ctrl (default parameters).
module tb_cpu_debug_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_addr;
    logic [7:0] cmd_data;
    logic [3:0] cmd_count;
    logic       halt_req;
    logic [3:0] pc;
    logic       imem_we;
    logic [3:0] imem_waddr;
    logic [7:0] imem_wdata;
    logic       cpu_en;
    logic       cpu_rst;
    logic       done;
    logic       err;
    logic [1:0] stop_cause;
`ifdef CPU_DEBUG_BREAKPOINT_EN
    logic       bp_en;
    logic [3:0] bp_addr;
`endif

    int checks = 0;
    int passes = 0;
    int en_total = 0;
    int we_total = 0;

    always #5 clk = ~clk;

    cpu_debug_ctrl dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_op_i     (cmd_op),
        .cmd_addr_i   (cmd_addr),
        .cmd_data_i   (cmd_data),
        .cmd_count_i  (cmd_count),
        .halt_req_i   (halt_req),
`ifdef CPU_DEBUG_BREAKPOINT_EN
        .bp_en_i      (bp_en),
        .bp_addr_i    (bp_addr),
`endif
        .pc_i         (pc),
        .imem_we_o    (imem_we),
        .imem_waddr_o (imem_waddr),
        .imem_wdata_o (imem_wdata),
        .cpu_en_o     (cpu_en),
        .cpu_rst_o    (cpu_rst),
        .done_o       (done),
        .err_o        (err),
        .stop_cause_o (stop_cause)
    );

    always @(negedge clk) begin
        if (cpu_en === 1'b1) en_total++;
        if (imem_we === 1'b1) we_total++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called one time unit after a rising edge; returns in the first cycle after acceptance.
    task automatic issue(input logic [1:0] op, input logic [3:0] addr, input logic [7:0] data,
                         input logic [3:0] count);
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        cmd_count = count;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 4'h0; cmd_data = 8'h00;
        cmd_count = 4'h0; halt_req = 1'b0; pc = 4'h0;
`ifdef CPU_DEBUG_BREAKPOINT_EN
        bp_en = 1'b0; bp_addr = 4'h0;
`endif
        repeat (2) tick();
        checks++; if (cpu_rst !== 1'b1) $display("FAIL reset_cpu_rst got %b want 1", cpu_rst);
        else passes++;
        checks++; if (cpu_en !== 1'b0) $display("FAIL reset_cpu_en got %b want 0", cpu_en);
        else passes++;
        checks++; if (imem_we !== 1'b0) $display("FAIL reset_imem_we got %b want 0", imem_we);
        else passes++;
        checks++;
        if ({done, err, stop_cause} !== 4'b0000)
            $display("FAIL reset_done_err_cause got %b want 0000", {done, err, stop_cause});
        else passes++;
        rst_n = 1'b1;
        tick();
        checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", cmd_ready);
        else passes++;
    endtask

    task automatic test_write();
        int we0 = we_total;
        int en0 = en_total;
        issue(2'b00, 4'h0, 8'h3B, 4'h0);
        checks++;
        if ({imem_we, imem_waddr, imem_wdata} !== {1'b1, 4'h0, 8'h3B})
            $display("FAIL write0_strobe got %b/%h/%h want 1/0/3b", imem_we, imem_waddr, imem_wdata);
        else passes++;
        checks++; if (cmd_ready !== 1'b0) $display("FAIL write0_ready got %b want 0", cmd_ready);
        else passes++;
        tick();
        checks++;
        if ({imem_we, done, cmd_ready} !== 3'b011)
            $display("FAIL write0_done got we=%b done=%b rdy=%b want 0/1/1", imem_we, done, cmd_ready);
        else passes++;
        issue(2'b00, 4'h1, 8'h5C, 4'h0);
        checks++;
        if ({imem_we, imem_waddr, imem_wdata} !== {1'b1, 4'h1, 8'h5C})
            $display("FAIL write1_strobe got %b/%h/%h want 1/1/5c", imem_we, imem_waddr, imem_wdata);
        else passes++;
        tick();
        checks++; if (done !== 1'b1) $display("FAIL write1_done got %b want 1", done);
        else passes++;
        tick();
        checks++;
        if (we_total - we0 != 2) $display("FAIL write_count got %0d want 2", we_total - we0);
        else passes++;
        checks++;
        if (en_total != en0 || cpu_rst !== 1'b1)
            $display("FAIL write_core_held got en=%0d rst=%b want 0/1", en_total - en0, cpu_rst);
        else passes++;
    endtask

    task automatic test_illegal_before_reset();
        int en0 = en_total;
        issue(2'b10, 4'h0, 8'h00, 4'h3);
        checks++;
        if ({err, cpu_en, done, cmd_ready} !== 4'b1001)
            $display("FAIL early_step got err=%b en=%b done=%b rdy=%b want 1/0/0/1",
                     err, cpu_en, done, cmd_ready);
        else passes++;
        tick();
        checks++; if (err !== 1'b0) $display("FAIL early_step_err_pulse got %b want 0", err);
        else passes++;
        issue(2'b11, 4'h0, 8'h00, 4'h0);
        checks++;
        if ({err, cpu_en} !== 2'b10) $display("FAIL early_run got err=%b en=%b want 1/0", err, cpu_en);
        else passes++;
        repeat (2) tick();
        checks++;
        if (en_total != en0 || cmd_ready !== 1'b1)
            $display("FAIL early_idle got en=%0d rdy=%b want 0/1", en_total - en0, cmd_ready);
        else passes++;
    endtask

    task automatic test_core_reset();
        int en0 = en_total;
        int we0 = we_total;
        issue(2'b01, 4'h0, 8'h00, 4'h0);
        checks++;
        if ({cpu_rst, cpu_en, done} !== 3'b110)
            $display("FAIL rst_seq got rst=%b en=%b done=%b want 1/1/0", cpu_rst, cpu_en, done);
        else passes++;
        tick();
        checks++;
        if ({cpu_rst, cpu_en, done, stop_cause, cmd_ready} !== 6'b001001)
            $display("FAIL rst_end got rst=%b en=%b done=%b cause=%0d rdy=%b want 0/0/1/0/1",
                     cpu_rst, cpu_en, done, stop_cause, cmd_ready);
        else passes++;
        tick();
        checks++;
        if (en_total - en0 != 1 || done !== 1'b0)
            $display("FAIL rst_en_cycles got %0d done=%b want 1/0", en_total - en0, done);
        else passes++;
        issue(2'b00, 4'h2, 8'hAA, 4'h0);
        checks++;
        if ({err, imem_we} !== 2'b10)
            $display("FAIL late_write got err=%b we=%b want 1/0", err, imem_we);
        else passes++;
        tick();
        checks++;
        if (we_total != we0) $display("FAIL late_write_count got %0d want 0", we_total - we0);
        else passes++;
    endtask

    task automatic test_step();
        int en0 = en_total;
        issue(2'b10, 4'h0, 8'h00, 4'h4);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({cpu_en, done} !== 2'b10)
                $display("FAIL step4_cycle%0d got en=%b done=%b want 1/0", i, cpu_en, done);
            else passes++;
            tick();
        end
        checks++;
        if ({cpu_en, done, stop_cause} !== 4'b0100)
            $display("FAIL step4_done got en=%b done=%b cause=%0d want 0/1/0", cpu_en, done, stop_cause);
        else passes++;
        tick();
        checks++;
        if (en_total - en0 != 4) $display("FAIL step4_count got %0d want 4", en_total - en0);
        else passes++;
        issue(2'b10, 4'h0, 8'h00, 4'h0);
        checks++;
        if ({cpu_en, done, stop_cause, cmd_ready} !== 5'b01001)
            $display("FAIL step0 got en=%b done=%b cause=%0d rdy=%b want 0/1/0/1",
                     cpu_en, done, stop_cause, cmd_ready);
        else passes++;
        tick();
        checks++;
        if (en_total - en0 != 4) $display("FAIL step0_count got %0d want 4", en_total - en0);
        else passes++;
    endtask

    task automatic test_step_halt();
        int en0 = en_total;
        issue(2'b10, 4'h0, 8'h00, 4'h5);
        repeat (2) tick();
        halt_req = 1'b1;
        #1;
        checks++;
        if ({cpu_en, done} !== 2'b00)
            $display("FAIL step_halt_gate got en=%b done=%b want 0/0", cpu_en, done);
        else passes++;
        tick();
        halt_req = 1'b0;
        checks++;
        if ({done, stop_cause, cmd_ready} !== 4'b1011)
            $display("FAIL step_halt_done got done=%b cause=%0d rdy=%b want 1/1/1",
                     done, stop_cause, cmd_ready);
        else passes++;
        tick();
        checks++;
        if (en_total - en0 != 2) $display("FAIL step_halt_count got %0d want 2", en_total - en0);
        else passes++;
    endtask

    task automatic test_run_halt();
        int en0 = en_total;
        issue(2'b11, 4'h0, 8'h00, 4'h0);
        repeat (19) tick();
        halt_req = 1'b1;
        #1;
        checks++;
        if (cpu_en !== 1'b0) $display("FAIL run_halt_gate got %b want 0", cpu_en);
        else passes++;
        tick();
        halt_req = 1'b0;
        checks++;
        if ({done, stop_cause, cmd_ready, cpu_en} !== 5'b10110)
            $display("FAIL run_halt_done got done=%b cause=%0d rdy=%b en=%b want 1/1/1/0",
                     done, stop_cause, cmd_ready, cpu_en);
        else passes++;
        checks++;
        if (en_total - en0 != 19) $display("FAIL run_count got %0d want 19", en_total - en0);
        else passes++;
        tick();
    endtask

    task automatic test_cmd_with_halt();
        halt_req = 1'b1;
        issue(2'b11, 4'h0, 8'h00, 4'h0);
        checks++;
        if ({cpu_en, cmd_ready, done, err} !== 4'b0000)
            $display("FAIL cmd_halt_first got en=%b rdy=%b done=%b err=%b want 0/0/0/0",
                     cpu_en, cmd_ready, done, err);
        else passes++;
        tick();
        halt_req = 1'b0;
        checks++;
        if ({done, stop_cause} !== 3'b101)
            $display("FAIL cmd_halt_done got done=%b cause=%0d want 1/1", done, stop_cause);
        else passes++;
        tick();
    endtask

    task automatic test_reset_mid_run();
        issue(2'b11, 4'h0, 8'h00, 4'h0);
        tick();
        checks++;
        if (cpu_en !== 1'b1) $display("FAIL midrun_en got %b want 1", cpu_en);
        else passes++;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cpu_en, cpu_rst, done, cmd_ready} !== 4'b0101)
            $display("FAIL midrun_reset got en=%b rst=%b done=%b rdy=%b want 0/1/0/1",
                     cpu_en, cpu_rst, done, cmd_ready);
        else passes++;
        tick();
        rst_n = 1'b1;
        tick();
        issue(2'b10, 4'h0, 8'h00, 4'h2);
        checks++;
        if ({err, cpu_en} !== 2'b10)
            $display("FAIL midrun_released_cleared got err=%b en=%b want 1/0", err, cpu_en);
        else passes++;
        tick();
    endtask

`ifdef CPU_DEBUG_BREAKPOINT_EN
    task automatic test_breakpoint();
        issue(2'b01, 4'h0, 8'h00, 4'h0);
        tick();
        bp_en = 1'b1; bp_addr = 4'b0110; pc = 4'b0110;
        #1;
        issue(2'b11, 4'h0, 8'h00, 4'h0);
        checks++;
        if (cpu_en !== 1'b1) $display("FAIL bp_first_cycle got %b want 1", cpu_en);
        else passes++;
        tick();
        pc = 4'b0111;
        #1;
        checks++;
        if (cpu_en !== 1'b1) $display("FAIL bp_other_pc got %b want 1", cpu_en);
        else passes++;
        tick();
        pc = 4'b0110;
        #1;
        checks++;
        if (cpu_en !== 1'b0) $display("FAIL bp_hit_gate got %b want 0", cpu_en);
        else passes++;
        tick();
        checks++;
        if ({done, stop_cause} !== 3'b110)
            $display("FAIL bp_done got done=%b cause=%0d want 1/2", done, stop_cause);
        else passes++;
        issue(2'b11, 4'h0, 8'h00, 4'h0);
        tick();
        halt_req = 1'b1;
        #1;
        checks++;
        if (cpu_en !== 1'b0) $display("FAIL bp_halt_gate got %b want 0", cpu_en);
        else passes++;
        tick();
        halt_req = 1'b0;
        checks++;
        if ({done, stop_cause} !== 3'b101)
            $display("FAIL bp_halt_cause got done=%b cause=%0d want 1/1", done, stop_cause);
        else passes++;
        issue(2'b10, 4'h0, 8'h00, 4'h2);
        checks++;
        if (cpu_en !== 1'b1) $display("FAIL bp_step_ignored0 got %b want 1", cpu_en);
        else passes++;
        tick();
        checks++;
        if (cpu_en !== 1'b1) $display("FAIL bp_step_ignored1 got %b want 1", cpu_en);
        else passes++;
        tick();
        bp_en = 1'b0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_illegal_before_reset();
        test_core_reset();
        test_step();
        test_step_halt();
        test_run_halt();
        test_cmd_with_halt();
        test_reset_mid_run();
`ifdef CPU_DEBUG_BREAKPOINT_EN
        test_breakpoint();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
